// File: rtl/print_arbiter.sv
// Round-robin collector for per-core PRINT results: one grant per cycle into a
// FIFO drained over a valid/ready port, with per-core stall back-pressure.
module print_arbiter #(
    parameter int NCORES = 4,
    parameter int DEPTH  = 8,
    parameter int CW     = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NCORES-1:0]          req,
    input  logic [NCORES*16-1:0]       req_data,
    output logic [NCORES-1:0]          print_stall,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [15:0]                out_data,
    output logic [CW-1:0]              out_core,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic [15:0]                print_total
);

    localparam int AW = $clog2(DEPTH);

    logic [CW+15:0] mem [DEPTH];
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  wr_ptr;
    logic [AW:0]    count;
    logic [CW-1:0]  rr_ptr;

    logic           pop;
    logic           can_push;
    logic           grant_valid;
    logic [CW-1:0]  grant;
    logic [15:0]    grant_data;

    assign out_valid  = (count != '0);
    assign pop        = out_valid & out_ready;
    assign can_push   = (count < (AW+1)'(DEPTH)) | pop;
    assign out_data   = mem[rd_ptr][15:0];
    assign out_core   = mem[rd_ptr][CW+15:16];
    assign fifo_count = count;

    // Scan starts at rr_ptr so the core after the last winner has priority.
    always_comb begin
        int idx;
        idx         = 0;
        grant_valid = 1'b0;
        grant       = '0;
        grant_data  = '0;
        for (int k = 0; k < NCORES; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NCORES) idx = idx - NCORES;
            if (!grant_valid && can_push && req[idx]) begin
                grant_valid = 1'b1;
                grant       = idx[CW-1:0];
                grant_data  = req_data[idx*16 +: 16];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NCORES; i++) begin
            print_stall[i] = req[i] & ~(grant_valid && (grant == CW'(i)));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr      <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            print_total <= '0;
        end else begin
            if (grant_valid) begin
                wr_ptr      <= wr_ptr + 1'b1;
                print_total <= print_total + 16'd1;
                rr_ptr      <= (grant == CW'(NCORES-1)) ? '0 : grant + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({grant_valid, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (grant_valid) begin
            mem[wr_ptr] <= {grant, grant_data};
        end
    end

endmodule

// File: doc/print_arbiter.md
Name: print_arbiter

Overview:
- Sits downstream of the per-core ALU stage and collects PRINT results from all NCORES cores.
- Grants at most one core per cycle using round-robin and enqueues {core id, value} into a FIFO.
- Drains the FIFO to a single output port over a valid/ready handshake.
- Back-pressures losing or blocked cores through a per-core stall, which the top level ORs into each core's core_stall. A stalled ALU holds its PRINT instruction, so its request persists.

Parameters:
- NCORES, 4, number of cores; 2..16.
- DEPTH, 8, FIFO entries; power of two, >= 2.
- CW, 4, width of the core-id field; must satisfy 2^CW >= NCORES.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous active-high reset.
- req  input  NCORES  per-core print request; bit i is core i's print_valid.
- req_data  input  NCORES*16  core i's print value at bits [i*16 +: 16].
- print_stall  output  NCORES  combinational; bit i=1 means core i must hold this cycle.
- out_valid  output  1  FIFO head is valid.
- out_ready  input  1  consumer accepts the head this cycle.
- out_data  output  16  head value.
- out_core  output  CW  head originating core id.
- fifo_count  output  $clog2(DEPTH)+1  current occupancy.
- print_total  output  16  count of enqueued prints; wraps modulo 2^16.

Behaviour:
- Reset (async, immediate on rst high):
  - rr_ptr=0, rd_ptr=0, wr_ptr=0, count=0, print_total=0.
  - Consequently out_valid=0 and print_stall=0.
  - out_data and out_core are don't-care while out_valid=0.
  - Reset mid-operation discards all FIFO contents; no entry survives.
- Pop:
  - pop = out_valid & out_ready.
  - out_valid = (count != 0).
  - out_data and out_core always reflect the entry at rd_ptr.
- Push enable: can_push = (count < DEPTH) | pop. Pushing on the same cycle as a pop while full is legal.
- Grant (combinational):
  - The first core i with req[i]=1, scanning rr_ptr, rr_ptr+1, ... mod NCORES.
  - No grant if no request is asserted or can_push=0.
- Stall:
  - print_stall[i] = req[i] & ~(grant_valid & grant==i).
  - Non-requesting cores are never stalled.
- On grant, at the clock edge:
  - mem[wr_ptr] <= {grant, req_data[grant]}.
  - wr_ptr <= wr_ptr+1, wrapping at DEPTH.
  - print_total <= print_total+1.
  - rr_ptr <= grant+1, with NCORES-1 wrapping to 0.
  - The granted core proceeds to its next instruction, so its req normally drops or changes next cycle.
- No grant: rr_ptr holds.
- Pop only: rd_ptr advances and count decrements.
- Push and pop together: both pointers advance and count is unchanged.
- Latency:
  - A granted value appears at the output one cycle after grant if the FIFO was empty.
  - There is no combinational path from req to out_valid.
- Full with no pop: every requesting core is stalled, nothing is written, and rr_ptr holds.
- Empty: out_ready is ignored and nothing is popped.
- Data capture: req_data is sampled only for the granted core in the grant cycle. Other lanes' data are don't-care.
- Single requester: it is granted every cycle while space is available, so there is no starvation penalty.
- Starvation bound: a continuously requesting core is granted within NCORES grant cycles.

Test Plan:
- Reset, then idle:
  - out_valid=0, print_stall=0, fifo_count=0, print_total=0.
- Single print:
  - Stimulus: req=4'b0100, req_data[2]=16'h0041 for one cycle, out_ready=1.
  - Grant cycle: print_stall=0.
  - Next cycle: out_valid=1, out_data=16'h0041, out_core=2.
  - Following cycle: out_valid=0 and print_total=1.
- Round-robin fairness:
  - Stimulus: req=4'b1111 held continuously, with each core dropping its req after being granted; out_ready=1; values 16'h0010+i.
  - Output order is cores 0,1,2,3.
  - First grant cycle: print_stall=4'b1110.
  - Final grant cycle: print_stall=4'b0000.
- Full FIFO:
  - Stimulus: out_ready=0, then 8 single-core prints, then core 1 requests.
  - Required: fifo_count=8 and print_stall[1]=1 held for the whole wait.
  - Then raise out_ready for one cycle: core 1 is granted that same cycle and fifo_count stays 8.
- Wrap-around: push 12 and pop 12 with out_ready toggling; data order is preserved across the pointer wrap, and fifo_count ends at 0.
- Async reset mid-run: assert rst with 5 entries queued; out_valid=0 and fifo_count=0 immediately, without waiting for a clock edge.
